cp0_ctrl: RTL
=============

CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 SHALL have parameter PRID, default 32'h0000_2020, read-only value of register 15.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port we  input  1  mtc0 write strobe.
REQ-005 SHALL have port addr  input  5  CP0 register number for mtc0/mfc0.
REQ-006 SHALL have port din  input  32  mtc0 write data.
REQ-007 SHALL have port pc_in  input  32  PC of the victim instruction in the commit stage.
REQ-008 SHALL have port bd_in  input  1  victim is in a branch delay slot.
REQ-009 SHALL have port exc_code_in  input  5  victim's exception code; 0 means none.
REQ-010 SHALL have port hw_int  input  6  external interrupt lines IP[7:2], level-sensitive.
REQ-011 SHALL have port eret  input  1  eret committing this cycle.
REQ-012 SHALL have port int_req  output  1  redirect fetch to 32'h4180 and flush.
REQ-013 SHALL have port epc_out  output  32  current EPC, the eret target.
REQ-014 SHALL have port dout  output  32  mfc0 read data.
REQ-015 SHALL have port exl  output  1  handler-mode flag.

Function
REQ-016 SHALL implement SR (12) = {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]}, Cause (13) = {BD[31], 15'b0, IP[15:10], 3'b0, ExcCode[6:2], 2'b0}, EPC (14), PRId (15); all other bits read 0.
REQ-017 SHALL read combinationally: dout = selected register; addr outside 12-15 returns 0.
REQ-018 SHALL sample hw_int into Cause.IP every cycle, independent of all other events.
REQ-019 SHALL compute int_req combinationally: int_req = !EXL & ((IE & |(IP_live & IM)) | (exc_code_in != 0)), where IP_live is hw_int.
REQ-020 SHALL give interrupts priority over exceptions: if both are pending, ExcCode = 0.
REQ-021 SHALL have two states: RUN (EXL=0) and HANDLER (EXL=1). RUN->HANDLER on int_req; HANDLER->RUN on eret; otherwise the state holds.
REQ-022 SHALL, on the int_req edge: set EXL=1; load ExcCode; load BD=bd_in; load EPC = bd_in ? {pc_in[31:2],2'b00}-4 : {pc_in[31:2],2'b00}.
REQ-023 SHALL ignore we in a cycle with int_req=1; the victim's mtc0 is squashed.
REQ-024 SHALL, on mtc0 (we & !int_req), write SR (IM, EXL, IE only) or EPC (din[31:2], low bits 0); writes to Cause or PRId are ignored.
REQ-025 SHALL give eret priority over an mtc0 to SR.EXL in the same cycle: EXL ends at 0.
REQ-026 SHALL not raise int_req during HANDLER; pending sources are held and retaken after eret when still asserted.
REQ-027 SHALL drive epc_out from the EPC register (one-cycle latency after capture).

Reset
REQ-028 SHALL clear, while reset=0: SR=0, Cause=0, EPC=0, state=RUN; int_req=0 except for a nonzero exc_code_in; exl=0; dout per addr.
REQ-029 SHALL discard an exception whose capture edge coincides with reset assertion; no EPC or EXL update.

Configuration
REQ-030 SHALL honour macro CP0_BD_EN: when defined, apply BD capture and the EPC-4 rule (REQ-022); when undefined, force BD=0 and set EPC = {pc_in[31:2],2'b00} regardless of bd_in.

Verification
REQ-031 SHALL test this: SR=32'h0000_0401, hw_int=6'b000001 -> int_req=1 same cycle; next cycle EXL=1, ExcCode=0, EPC=pc_in=32'h0000_3010.
REQ-032 SHALL test this: exc_code_in=5'd4, pc_in=32'h0000_3022, bd_in=0 -> EPC=32'h0000_3020, Cause[6:2]=4, exl=1.
REQ-033 SHALL test this, with CP0_BD_EN defined: bd_in=1, pc_in=32'h0000_3104, exc 10 -> EPC=32'h0000_3100, Cause[31]=1; with it undefined -> EPC=32'h0000_3104, Cause[31]=0.
REQ-034 SHALL test this: EXL=1, hw_int asserted -> int_req stays 0; eret -> EXL=0 next cycle, int_req=1 in the following cycle.
REQ-035 SHALL test this: we=1, addr=12, din=32'hFFFF_FFFF with a simultaneous exception -> SR unchanged, exception captured; we=1, addr=13 -> Cause unchanged; mfc0 addr=15 -> PRID.
REQ-036 SHALL test this: reset driven low asynchronously mid-HANDLER -> exl=0, epc_out=0 before the next clk edge.

Source files
------------

// File: rtl/cp0_ctrl.sv
// MIPS-style CP0 control block: SR, Cause, EPC and PRId with exception/interrupt capture.
// Optional macro CP0_BD_EN enables branch-delay capture (Cause.BD and the EPC-4 rule).
module cp0_ctrl #(
  parameter logic [31:0] PRID = 32'h0000_2020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] din,
  input  logic [31:0] pc_in,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic        int_req,
  output logic [31:0] epc_out,
  output logic [31:0] dout,
  output logic        exl
);

  localparam logic [4:0] AddrSr    = 5'd12;
  localparam logic [4:0] AddrCause = 5'd13;
  localparam logic [4:0] AddrEpc   = 5'd14;
  localparam logic [4:0] AddrPrid  = 5'd15;

  // The run/handler state is the architectural SR.EXL bit.
  typedef enum logic [0:0] {
    StRun     = 1'b0,
    StHandler = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  im_q, im_d;
  logic        ie_q, ie_d;
  logic [5:0]  ip_q;
  logic        bd_q, bd_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:2] epc_q, epc_d;

  logic        int_pending;
  logic        exc_pending;
  logic        mtc0;
  logic [31:0] victim_pc;
  logic        capture_bd;
  logic [31:0] capture_epc;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic        unused_in;

  assign unused_in = ^{bd_in, pc_in[1:0]};

  // Source decode and victim capture values.
  always_comb begin
    int_pending = ie_q & (|(hw_int & im_q));
    exc_pending = (exc_code_in != 5'd0);
    int_req     = (state_q == StRun) & (int_pending | exc_pending);
    mtc0        = we & ~int_req;
    victim_pc   = {pc_in[31:2], 2'b00};
`ifdef CP0_BD_EN
    capture_bd  = bd_in;
    capture_epc = bd_in ? (victim_pc - 32'd4) : victim_pc;
`else
    capture_bd  = 1'b0;
    capture_epc = victim_pc;
`endif
  end

  // Next-state: capture wins over mtc0; eret wins over an mtc0 to SR.EXL.
  always_comb begin
    state_d    = state_q;
    im_d       = im_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;

    if (int_req) begin
      state_d    = StHandler;
      exc_code_d = int_pending ? 5'd0 : exc_code_in;
      bd_d       = capture_bd;
      epc_d      = capture_epc[31:2];
    end else begin
      if (mtc0) begin
        case (addr)
          AddrSr: begin
            im_d    = din[15:10];
            ie_d    = din[0];
            state_d = din[1] ? StHandler : StRun;
          end
          AddrEpc: epc_d = din[31:2];
          default: ;
        endcase
      end
      if (eret) begin
        state_d = StRun;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StRun;
      im_q       <= 6'd0;
      ie_q       <= 1'b0;
      ip_q       <= 6'd0;
      bd_q       <= 1'b0;
      exc_code_q <= 5'd0;
      epc_q      <= 30'd0;
    end else begin
      state_q    <= state_d;
      im_q       <= im_d;
      ie_q       <= ie_d;
      ip_q       <= hw_int;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  // Register views and mfc0 read mux.
  always_comb begin
    exl        = (state_q == StHandler);
    epc_out    = {epc_q, 2'b00};
    sr_word    = {16'd0, im_q, 8'd0, exl, ie_q};
    cause_word = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
    case (addr)
      AddrSr:    dout = sr_word;
      AddrCause: dout = cause_word;
      AddrEpc:   dout = epc_out;
      AddrPrid:  dout = PRID;
      default:   dout = 32'd0;
    endcase
  end

endmodule
